sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 113 +++++++++++
 tb/tb_sram_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: 32-bit CPU load/store port onto a 16-bit asynchronous SRAM.
// Each access takes two halfword cycles (low then high), a programmable idle
// gap, and a one-cycle DONE handshake. ready drops combinationally on a request
// so the pipeline freezes in the same cycle the request appears.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    // Counter only has to reach WAIT_CYCLES-1; keep at least one bit so the
    // WAIT_CYCLES = 0 build still elaborates (WAIT is unreachable there).
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [31:0]   BASE     = 32'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t          state;
    req_t            req_q;
    logic [CW-1:0]   cnt;

    logic            req_in;
    logic [31:0]     off_in;
    logic [31:0]     off_q;
    logic [16:0]     word_in;
    logic [16:0]     word_q;
    logic            unused_ok;

    assign req_in  = wr_en | rd_en;
    // Word index is a 32-bit wrap-around subtract; only 17 bits reach the SRAM.
    assign off_in  = address - BASE;
    assign off_q   = req_q.addr - BASE;
    assign word_in = off_in[18:2];
    assign word_q  = off_q[18:2];

    // Low halfword is launched straight from the inputs on the IDLE edge, so
    // the registered copy of it is never read back.
    assign unused_ok = ^{off_in[31:19], off_in[1:0], off_q[31:19], off_q[1:0],
                         req_q.wdata[15:0]};

    // Pipeline stall: low as soon as a request is seen, high again only in DONE.
    assign ready = (state == IDLE) ? ~req_in : (state == DONE);

    // Access sequencer: state, request capture, SRAM bus drive and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_q       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_in) begin
                        // wr_en wins when both are asserted
                        req_q       <= '{is_wr: wr_en, addr: address, wdata: write_data};
                        sram_addr   <= {word_in, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : 16'h0;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                        state       <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    if (!req_q.is_wr) read_data[15:0] <= sram_dq_in;
                    sram_addr   <= {word_q, 1'b1};
                    sram_dq_out <= req_q.is_wr ? req_q.wdata[31:16] : 16'h0;
                    state       <= ACC_HI;
                end
                ACC_HI: begin
                    if (!req_q.is_wr) read_data[31:16] <= sram_dq_in;
                    sram_addr   <= '0;
                    sram_dq_out <= '0;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                    cnt         <= '0;
                    state       <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_LAST) state <= DONE;
                    else                 cnt   <= cnt + CW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of accesses against a 256-entry halfword
// SRAM model, expected read data queued on issue and checked at DONE, plus
// hand-written back-to-back and mid-access reset sequences.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_in (sram_dq_in),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write on the edge while we_n is low.
    logic [15:0] mem [0:255];
    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (!sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;   // read_data at DONE (unchanged value for writes)
        logic [17:0] exp_a0;   // halfword address of the low access
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    // One full access; inputs are driven at a negedge and sampled 1ns later.
    task automatic access(input vec_t v, input bit hold);
        int          busy = 0;
        int          nwe  = 0;
        int          noe  = 0;
        logic [17:0] a_lo = '0;
        logic [17:0] a_hi = '0;
        logic [15:0] d_lo = '0;
        logic [15:0] d_hi = '0;
        logic [31:0] exp;
        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        sb_q.push_back(v.exp_rd);
        #1;
        chk("req_ready", {31'b0, ready}, 32'd0);
        while (!ready && busy < 20) begin
            busy++;
            if (!sram_we_n) nwe++;
            if (sram_dq_oe) noe++;
            if (busy == 2) begin a_lo = sram_addr; d_lo = sram_dq_out; end
            if (busy == 3) begin a_hi = sram_addr; d_hi = sram_dq_out; end
            @(negedge clk); #1;
        end
        if (!hold) begin wr_en = 1'b0; rd_en = 1'b0; end
        chk("latency", busy, 32'd6);
        chk("we_cycles", nwe, v.wr ? 32'd2 : 32'd0);
        chk("oe_cycles", noe, v.wr ? 32'd2 : 32'd0);
        chk("addr_lo", {14'b0, a_lo}, {14'b0, v.exp_a0});
        chk("addr_hi", {14'b0, a_hi}, {14'b0, v.exp_a0[17:1], 1'b1});
        if (v.wr) begin
            chk("data_lo", {16'b0, d_lo}, {16'b0, v.exp_lo});
            chk("data_hi", {16'b0, d_hi}, {16'b0, v.exp_hi});
        end
        chk("done_bus_ctl", {30'b0, sram_we_n, sram_dq_oe}, {30'b0, 1'b1, 1'b0});
        chk("done_bus_addr", {14'b0, sram_addr}, 32'd0);
        chk("done_bus_dq", {16'b0, sram_dq_out}, 32'd0);
        exp = sb_q.pop_front();
        chk("read_data", read_data, exp);
    endtask

    vec_t vecs [9];
    vec_t v;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 32'h00000000, 18'h00000, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,   32'h0,        32'hDEADBEEF, 18'h00000, 16'h0,    16'h0};
        vecs[2] = '{1'b1, 1'b0, 32'd1032,   32'h12345678, 32'hDEADBEEF, 18'h00004, 16'h5678, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 32'd1024,   32'hCAFEF00D, 32'hDEADBEEF, 18'h00000, 16'hF00D, 16'hCAFE};
        vecs[4] = '{1'b0, 1'b1, 32'd1032,   32'h0,        32'h12345678, 18'h00004, 16'h0,    16'h0};
        vecs[5] = '{1'b0, 1'b1, 32'd1024,   32'h0,        32'hCAFEF00D, 18'h00000, 16'h0,    16'h0};
        vecs[6] = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 32'hCAFEF00D, 18'h3FFFE, 16'h5A5A, 16'hA5A5};
        vecs[7] = '{1'b0, 1'b1, 32'd1020,   32'h0,        32'hA5A55A5A, 18'h3FFFE, 16'h0,    16'h0};
        vecs[8] = '{1'b0, 1'b1, 32'd525312, 32'h0,        32'hCAFEF00D, 18'h00000, 16'h0,    16'h0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {14'b0, sram_addr}, 32'd0);
        chk("rst_dq", {16'b0, sram_dq_out}, 32'd0);
        chk("rst_rd", read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_ready", {31'b0, ready}, 32'd1);

        for (int i = 0; i < 9; i++) access(vecs[i], 1'b0);

        // back-to-back: rd_en held across DONE, second request must stall at once
        v = '{1'b0, 1'b1, 32'd1032, 32'h0, 32'h12345678, 18'h00004, 16'h0, 16'h0};
        access(v, 1'b1);
        access(v, 1'b0);

        // reset in WAIT of a read
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1024;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_busy", {31'b0, ready}, 32'd0);
        chk("pre_rst_rd", read_data, 32'hCAFEF00D);
        rst = 1'b1; rd_en = 1'b0;
        @(negedge clk); #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_rd", read_data, 32'd0);
        chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("abort_addr", {14'b0, sram_addr}, 32'd0);
        rst = 1'b0;
        // a full-latency access afterwards shows the FSM restarted from IDLE
        v = '{1'b1, 1'b0, 32'd1028, 32'h0BADC0DE, 32'h00000000, 18'h00002, 16'hC0DE, 16'h0BAD};
        access(v, 1'b0);
        v = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'h0BADC0DE, 18'h00002, 16'h0, 16'h0};
        access(v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
